// File: rtl/fetch_issue_queue.sv
// Instruction fetch front end: drives PC into a one-cycle memory stage, buffers returned
// instructions in an in-order FIFO and issues the decoded head to the adder or multiplier RS.
module fetch_issue_queue #(
    parameter int DEPTH    = 4,
    parameter int PROG_LEN = 6
) (
    input  logic        clk1,
    input  logic        rst_n,
    output logic [3:0]  pc,
    input  logic [15:0] instr_in,
    output logic        issue_valid,
    output logic        issue_unit,
    output logic [1:0]  issue_op,
    output logic [3:0]  issue_rd,
    output logic [3:0]  issue_rs1,
    output logic [3:0]  issue_rs2,
    input  logic        add_rdy,
    input  logic        mul_rdy,
    output logic        illegal,
    output logic        done
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [4:0]    PLEN    = 5'(PROG_LEN);
    localparam logic [CW+1:0] DEPTH_C = (CW + 2)'(DEPTH);

    logic [3:0]    pc_q, pc_d;
    logic          fetch_v_q, fetch_v_d;
    logic          pend_q;
    logic [4:0]    next_addr_q, next_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          illegal_q, illegal_d;
    logic          done_q, done_d;
    logic [15:0]   queue_q [DEPTH];

    logic [CW+1:0] occupancy;
    logic          fetch_go;
    logic [15:0]   head;
    logic          head_legal, not_empty, fire, drop, push, pop;

    // Credit counts queued plus in-flight entries; the same-cycle pop is deliberately ignored
    // so that rdy never reaches pc combinationally.
    assign occupancy = (CW + 2)'(count_q) + (CW + 2)'(fetch_v_q) + (CW + 2)'(pend_q);
    assign fetch_go  = (next_addr_q < PLEN) && (occupancy < DEPTH_C);

    assign head        = queue_q[rd_ptr_q];
    assign head_legal  = (head[15:14] == 2'b00);
    assign not_empty   = (count_q != '0);
    assign issue_valid = not_empty && head_legal;
    assign issue_unit  = head[13];
    assign issue_op    = head[13:12];
    assign issue_rd    = head[11:8];
    assign issue_rs1   = head[7:4];
    assign issue_rs2   = head[3:0];

    assign fire = issue_valid && (issue_unit ? mul_rdy : add_rdy);
    assign drop = not_empty && !head_legal;
    assign pop  = fire || drop;
    assign push = pend_q;

    always_comb begin
        pc_d        = pc_q;
        fetch_v_d   = fetch_go;
        next_addr_d = next_addr_q;
        if (fetch_go) begin
            pc_d        = next_addr_q[3:0];
            next_addr_d = next_addr_q + 5'd1;
        end
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        illegal_d = illegal_q | drop;
        done_d    = done_q | ((next_addr_q == PLEN) && !fetch_v_q && !pend_q && !not_empty);
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            fetch_v_q   <= 1'b0;
            pend_q      <= 1'b0;
            next_addr_q <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            illegal_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            fetch_v_q   <= fetch_v_d;
            pend_q      <= fetch_v_q;
            next_addr_q <= next_addr_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            illegal_q   <= illegal_d;
            done_q      <= done_d;
        end
    end

    // Queue storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk1) begin
        if (push) queue_q[wr_ptr_q] <= instr_in;
    end

    assign pc      = pc_q;
    assign illegal = illegal_q;
    assign done    = done_q;

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Bench for fetch_issue_queue: synchronous memory model, program-order scoreboard and
// directed plus randomized ready patterns.
module tb_fetch_issue_queue;
    localparam int DEPTH    = 4;
    localparam int PROG_LEN = 6;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  pc;
    logic [15:0] instr_in;
    logic        issue_valid, issue_unit;
    logic [1:0]  issue_op;
    logic [3:0]  issue_rd, issue_rs1, issue_rs2;
    logic        add_rdy = 1'b0, mul_rdy = 1'b0;
    logic        illegal, done;

    logic [15:0] prog [16];
    int n_vec = 0, n_err = 0;
    int exp_idx, cyc, first_iv;
    bit saw_ill;

    fetch_issue_queue #(.DEPTH(DEPTH), .PROG_LEN(PROG_LEN)) dut (
        .clk1(clk1), .rst_n(rst_n), .pc(pc), .instr_in(instr_in),
        .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_op(issue_op),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .add_rdy(add_rdy), .mul_rdy(mul_rdy), .illegal(illegal), .done(done)
    );

    always #5 clk1 = ~clk1;

    // Memory stage: samples pc on the rising edge and returns the word on that edge.
    always @(posedge clk1) instr_in <= prog[pc];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [15:0] ins);
        return ins[15:12] < 4'd4;
    endfunction

    function automatic logic [14:0] decode(input logic [15:0] ins);
        logic       u;
        logic [1:0] op;
        case (ins[15:12])
            4'h0:    begin u = 1'b0; op = 2'd0; end
            4'h1:    begin u = 1'b0; op = 2'd1; end
            4'h2:    begin u = 1'b1; op = 2'd2; end
            default: begin u = 1'b1; op = 2'd3; end
        endcase
        return {u, op, ins[11:0]};
    endfunction

    task automatic load_base();
        logic [15:0] base [6] = '{16'h2123, 16'h0345, 16'h0267, 16'h089A, 16'h27AB, 16'h1CDE};
        for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
        for (int i = 0; i < 6; i++) prog[i] = base[i];
    endtask

    task automatic init_model();
        exp_idx = 0; saw_ill = 0; cyc = 0; first_iv = -1;
    endtask

    task automatic do_reset();
        @(negedge clk1);
        rst_n = 1'b0; add_rdy = 1'b0; mul_rdy = 1'b0;
        @(negedge clk1); #1;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clk1);
        rst_n = 1'b1;
        init_model();
    endtask

    // One clock: drive ready at the falling edge, sample outputs 1 time unit later, and
    // retire the expected instruction whenever the sampled handshake will fire.
    task automatic step(input logic a, input logic m);
        logic        fire;
        logic [14:0] obs;
        @(negedge clk1);
        add_rdy = a; mul_rdy = m;
        #1;
        cyc++;
        chk("no_overflow", 32'(dut.pend_q && (int'(dut.count_q) == DEPTH)), 0);
        if (issue_valid === 1'b1 && first_iv < 0) first_iv = cyc;
        fire = issue_valid && (issue_unit ? mul_rdy : add_rdy);
        if (fire === 1'b1) begin
            while (exp_idx < PROG_LEN && !legal(prog[exp_idx])) begin
                saw_ill = 1; exp_idx++;
            end
            if (exp_idx >= PROG_LEN) chk("spurious_issue", 1, 0);
            else begin
                obs = {issue_unit, issue_op, issue_rd, issue_rs1, issue_rs2};
                chk($sformatf("issue%0d", exp_idx), 32'(obs), 32'(decode(prog[exp_idx])));
                chk("illegal_flag", 32'(illegal), 32'(saw_ill));
                chk("done_early", 32'(done), 0);
                exp_idx++;
            end
        end
    endtask

    task automatic run_to_done(input int mode, input bit timing);
        int   budget;
        logic a, m;
        budget = 300;
        while (done !== 1'b1 && budget > 0) begin
            case (mode)
                0:       begin a = 1'b1; m = 1'b1; end
                1:       begin a = 1'($urandom); m = 1'b1; end
                default: begin a = 1'($urandom); m = 1'($urandom); end
            endcase
            step(a, m);
            if (timing && cyc <= PROG_LEN) chk($sformatf("pc_seq%0d", cyc), 32'(pc), 32'(cyc - 1));
            budget--;
        end
        chk("done_timeout", 32'(budget > 0), 1);
        while (exp_idx < PROG_LEN && !legal(prog[exp_idx])) begin
            saw_ill = 1; exp_idx++;
        end
        chk("all_issued", 32'(exp_idx), 32'(PROG_LEN));
        chk("illegal_end", 32'(illegal), 32'(saw_ill));
        if (timing) chk("first_issue_cycle", 32'(first_iv), 3);
    endtask

    initial begin
        int drain_pc [4] = '{3, 3, 4, 5};
        int k;

        // Straight-line program with both stations always ready.
        load_base();
        do_reset();
        run_to_done(0, 1);

        // Both stations stalled: fetch must stop with the queue exactly full.
        load_base();
        do_reset();
        repeat (12) step(1'b0, 1'b0);
        chk("hold_pc", 32'(pc), 3);
        chk("hold_count", 32'(dut.count_q), 32'(DEPTH));
        chk("hold_issue_valid", 32'(issue_valid), 1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            chk("drain_issue_valid", 32'(issue_valid), 1);
            chk($sformatf("drain_pc%0d", i), 32'(pc), 32'(drain_pc[i]));
        end
        run_to_done(0, 0);

        // Head-of-line blocking: MUL at head, ADD behind it, only the adder ready.
        load_base();
        do_reset();
        repeat (8) step(1'b1, 1'b0);
        chk("hol_no_issue", 32'(exp_idx), 0);
        chk("hol_issue_valid", 32'(issue_valid), 1);
        chk("hol_unit", 32'(issue_unit), 1);
        chk("hol_op", 32'(issue_op), 2);
        step(1'b1, 1'b1);
        chk("hol_mul_fired", 32'(exp_idx), 1);
        step(1'b1, 1'b1);
        chk("hol_add_fired", 32'(exp_idx), 2);
        run_to_done(0, 0);

        // Illegal opcode at address 2.
        load_base();
        prog[2] = 16'h5267;
        do_reset();
        run_to_done(0, 1);

        // Asynchronous reset after three issues, then a full rerun.
        load_base();
        do_reset();
        k = 0;
        while (exp_idx < 3 && k < 30) begin
            step(1'b1, 1'b1);
            k++;
        end
        chk("pre_reset_issues", 32'(exp_idx), 3);
        @(posedge clk1); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", 32'(pc), 0);
        chk("async_rst_count", 32'(dut.count_q), 0);
        chk("async_rst_issue_valid", 32'(issue_valid), 0);
        chk("async_rst_done", 32'(done), 0);
        @(negedge clk1);
        rst_n = 1'b1;
        init_model();
        run_to_done(0, 1);

        // Randomized programs and ready patterns.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
            for (int i = 0; i < PROG_LEN; i++) begin
                prog[i][11:0]  = 12'($urandom);
                prog[i][15:12] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(4, 15))
                                                              : 4'($urandom_range(0, 3));
            end
            do_reset();
            run_to_done((t % 2 == 0) ? 1 : 2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_issue_queue.md
Name: fetch_issue_queue

Overview:
- Front end between the program counter and the reservation stations of the Tomasulo core.
- Drives the 4-bit PC into the instruction memory read stage and captures the 16-bit instruction that stage returns one clock later.
- Buffers fetched instructions in a small in-order FIFO, decodes the head entry, and issues it to the adder or multiplier reservation station using a valid/ready handshake.

Parameters:
- DEPTH, 4, queue entries (power of 2, at least 2)
- PROG_LEN, 6, number of instructions fetched; addresses 0..PROG_LEN-1, at most 16

Ports:
- clk1  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- pc  output  4  fetch address to the instruction memory stage
- instr_in  input  16  instruction returned by the memory stage
- issue_valid  output  1  head entry is decoded and legal
- issue_unit  output  1  0 = adder RS, 1 = multiplier RS
- issue_op  output  2  0 = ADD, 1 = SUB, 2 = MUL, 3 = DIV
- issue_rd  output  4  instr[11:8]
- issue_rs1  output  4  instr[7:4]
- issue_rs2  output  4  instr[3:0]
- add_rdy  input  1  adder RS can accept this cycle
- mul_rdy  input  1  multiplier RS can accept this cycle
- illegal  output  1  sticky; an illegal opcode was dropped
- done  output  1  all PROG_LEN fetched, nothing in flight, queue empty

Behaviour:
- Clock and reset: one clock (clk1). Reset is asynchronous and active-low (rst_n).
- Reset values: pc=0, fetch_v=0, pend=0, next_addr=0, count=0, read/write pointers 0, illegal=0, done=0.
- Decoded outputs are combinational from the head entry. Their value is don't-care when issue_valid=0.
- Memory timing: the memory stage samples pc on each rising edge and updates instr_in on that same edge.
  - Edge k: registers pc=P with fetch_v=1.
  - Edge k+1: memory reads P; pend<=fetch_v. During cycle k+1, instr_in=mem[P] and pend=1.
  - Edge k+2: if pend=1, instr_in is written to the queue tail.
  - Fetch-to-queue latency is 2 edges.
- Fetch credit: fetch_go = (next_addr < PROG_LEN) && (count + fetch_v + pend < DEPTH).
  - The pop in the current cycle is ignored, which is conservative and avoids a combinational path from rdy to pc.
  - On fetch_go: pc<=next_addr, fetch_v<=1, next_addr<=next_addr+1.
  - Otherwise fetch_v<=0 and pc holds.
  - next_addr saturates at PROG_LEN; it never wraps.
- The queue never overflows by construction. The bench asserts that a push never occurs while count==DEPTH.
- Decode of head opcode instr[15:12]:
  - 0000 ADD, unit 0
  - 0001 SUB, unit 0
  - 0010 MUL, unit 1
  - 0011 DIV, unit 1
  - 0100..1111 illegal
- Issue: issue_valid = (count!=0) && legal(head).
  - fire = issue_valid && (issue_unit ? mul_rdy : add_rdy). On fire, pop.
  - The non-target ready is ignored.
- Illegal head: pops in one cycle with no issue_valid and sets illegal<=1. illegal is cleared only by reset.
- Head-of-line blocking: strictly in order. A MUL waiting on mul_rdy blocks a following ADD even if add_rdy=1.
- Simultaneous push and pop (fire or illegal drop) in the same cycle: count unchanged, both pointers advance modulo DEPTH.
- Empty: issue_valid=0. The rdy inputs have no effect.
- done<=1 when next_addr==PROG_LEN && !fetch_v && !pend && count==0. done stays 1 until reset.
- PROG_LEN=0: done=1 on the first edge after reset. No fetch ever occurs.
- Reset asserted mid-operation:
  - All state clears immediately, asynchronously.
  - In-flight instructions are discarded.
  - After release, fetch restarts from address 0 on the first edge.

Test Plan:
- Reset release, rdy both 1, memory[0..5]={2123,0345,0267,089A,27AB,xxxx hex} -> pc sequence 0,1,2,3,4,5 on consecutive edges. The first issue_valid occurs 2 edges after pc=0. Issues are MUL rd1 rs2 rs3, ADD rd3 rs4 rs5, ADD rd2 rs6 rs7, ADD rd8 rs9 rsA, MUL rd7 rsA rsB, then the sixth entry decoded from mem[5]. done rises once the last entry has popped.
- Hold add_rdy=mul_rdy=0 -> fetch stops once count + in-flight reaches 4. pc freezes at 3 and the queue fills to exactly 4. After releasing rdy, one entry pops per cycle and fetch resumes with pc=4.
- Head MUL with mul_rdy=0 and add_rdy=1, next entry ADD -> nothing issues, issue_unit=1 held stable. Raising mul_rdy -> MUL fires, then ADD fires on the next edge.
- Opcode 0101 at address 2 -> that entry is dropped with issue_valid=0 in its head cycle, illegal=1 thereafter. The other five instructions issue normally.
- Assert rst_n low for one cycle after 3 issues -> pc=0, count=0 and issue_valid=0 immediately. After release, fetch restarts from address 0 and all 6 issue again.
- Toggle add_rdy at random every cycle -> the issued stream equals program order, with no duplicates, no losses and no overflow assertion.
